// File: rtl/game_round_ctrl.sv
// Round sequencer for the 4-player pedra/papel/tesoura betting game: collects moves/bets, evaluates, pays out.
// Optional round timeout in COLLECT is enabled by defining GAME_ROUND_TIMEOUT_EN.
module game_round_ctrl #(
  parameter logic [7:0] SALDO_INI      = 8'd100,
  parameter int         TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       jog_valid,
  input  logic [1:0] jog_id,
  input  logic [1:0] jog_move,
  input  logic [6:0] jog_aposta,
  output logic       jog_ready,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] vencedores,
  output logic       empate,
  output logic       resultado_valid,
  output logic       ronda_abortada,
  output logic [7:0] saldo_j1,
  output logic [7:0] saldo_j2,
  output logic [7:0] saldo_j3,
  output logic [7:0] saldo_j4,
  output logic [7:0] ronda_num
);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, PAYOUT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      venc_q, venc_d;
  logic            empate_q, empate_d;
  logic [3:0]      win_q, win_d;
  logic            tie_q, tie_d;
  logic            erro_q, erro_d;
  logic            rv_q, rv_d;
  logic            ready_q, ready_d;
  logic            ocupado_q, ocupado_d;
  logic [7:0]      ronda_q, ronda_d;
  logic [3:0][7:0] saldo_q, saldo_d;
  logic [3:0][1:0] move_q;
  logic [3:0][6:0] bet_q;
  logic            bad, take;

`ifdef GAME_ROUND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ab_q, ab_d;
`endif

  function automatic logic [6:0] clamp_bet(input logic [6:0] bet, input logic [7:0] saldo);
    logic [6:0] r;
    if ({1'b0, bet} > saldo) r = saldo[6:0];
    else                     r = bet;
    return r;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [6:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sub_bet(input logic [7:0] a, input logic [6:0] b);
    return a - {1'b0, b};
  endfunction

  // Returns {tie, winner_mask}; a winner exists only when exactly two distinct moves were played.
  function automatic logic [4:0] eval_round(input logic [3:0][1:0] moves);
    logic [2:0] seen;
    logic [1:0] w;
    logic [3:0] m;
    logic       tie;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      case (moves[i])
        2'd0:    seen[0] = 1'b1;
        2'd1:    seen[1] = 1'b1;
        default: seen[2] = 1'b1;
      endcase
    end
    tie = 1'b0;
    w   = 2'd0;
    case (seen)
      3'b011:  w = 2'd1;
      3'b110:  w = 2'd2;
      3'b101:  w = 2'd0;
      default: tie = 1'b1;
    endcase
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = !tie && (moves[i] == w);
    return {tie, m};
  endfunction

  assign bad  = (jog_move == 2'd3) || mask_q[jog_id];
  assign take = jog_valid && ready_q && !bad;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    venc_d   = venc_q;
    empate_d = empate_q;
    win_d    = win_q;
    tie_d    = tie_q;
    ronda_d  = ronda_q;
    saldo_d  = saldo_q;
    erro_d   = 1'b0;
    rv_d     = 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
    cnt_d    = cnt_q;
    ab_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          mask_d   = '0;
          venc_d   = '0;
          empate_d = 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      COLLECT: begin
        if (jog_valid && ready_q) begin
          if (bad) erro_d = 1'b1;
          else     mask_d[jog_id] = 1'b1;
        end
        if (&mask_d) state_d = EVAL;
`ifdef GAME_ROUND_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CICLOS - 1)) begin
          state_d = IDLE;
          ab_d    = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
`endif
      end
      EVAL: begin
        {tie_d, win_d} = eval_round(move_q);
        state_d        = PAYOUT;
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          if (!tie_q) saldo_d[i] = win_q[i] ? sat_add(saldo_q[i], bet_q[i]) : sub_bet(saldo_q[i], bet_q[i]);
        end
        venc_d   = win_q;
        empate_d = tie_q;
        ronda_d  = ronda_q + 8'd1;
        rv_d     = 1'b1;
        state_d  = IDLE;
      end
    endcase
    ready_d   = (state_d == COLLECT);
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      venc_q    <= '0;
      empate_q  <= 1'b0;
      ronda_q   <= '0;
      saldo_q   <= {4{SALDO_INI}};
      erro_q    <= 1'b0;
      rv_q      <= 1'b0;
      ready_q   <= 1'b0;
      ocupado_q <= 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
      cnt_q     <= '0;
      ab_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      venc_q    <= venc_d;
      empate_q  <= empate_d;
      ronda_q   <= ronda_d;
      saldo_q   <= saldo_d;
      erro_q    <= erro_d;
      rv_q      <= rv_d;
      ready_q   <= ready_d;
      ocupado_q <= ocupado_d;
`ifdef GAME_ROUND_TIMEOUT_EN
      cnt_q     <= cnt_d;
      ab_q      <= ab_d;
`endif
    end
  end

  // Round payload holds only what the current round wrote; a reset discards it implicitly.
  always_ff @(posedge clk) begin
    if (take) begin
      move_q[jog_id] <= jog_move;
      bet_q[jog_id]  <= clamp_bet(jog_aposta, saldo_q[jog_id]);
    end
    win_q <= win_d;
    tie_q <= tie_d;
  end

  assign jog_ready       = ready_q;
  assign erro            = erro_q;
  assign ocupado         = ocupado_q;
  assign vencedores      = venc_q;
  assign empate          = empate_q;
  assign resultado_valid = rv_q;
  assign ronda_num       = ronda_q;
  assign saldo_j1        = saldo_q[0];
  assign saldo_j2        = saldo_q[1];
  assign saldo_j3        = saldo_q[2];
  assign saldo_j4        = saldo_q[3];

`ifdef GAME_ROUND_TIMEOUT_EN
  assign ronda_abortada = ab_q;
`else
  // Constant 0 that still references the timeout parameter when the feature is compiled out.
  assign ronda_abortada = (TIMEOUT_CICLOS < 0);
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: per-cycle comparison against a round-level model plus literal pins.
`timescale 1ns/1ps
module tb_game_round_ctrl;
  localparam logic [7:0] INI = 8'd100;
`ifdef GAME_ROUND_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, jog_valid;
  logic [1:0] jog_id, jog_move;
  logic [6:0] jog_aposta;
  logic       jog_ready, erro, ocupado, empate, resultado_valid, ronda_abortada;
  logic [3:0] vencedores;
  logic [7:0] saldo_j1, saldo_j2, saldo_j3, saldo_j4, ronda_num;

  game_round_ctrl #(.SALDO_INI(INI), .TIMEOUT_CICLOS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .jog_valid(jog_valid), .jog_id(jog_id),
    .jog_move(jog_move), .jog_aposta(jog_aposta), .jog_ready(jog_ready), .erro(erro),
    .ocupado(ocupado), .vencedores(vencedores), .empate(empate),
    .resultado_valid(resultado_valid), .ronda_abortada(ronda_abortada),
    .saldo_j1(saldo_j1), .saldo_j2(saldo_j2), .saldo_j3(saldo_j3), .saldo_j4(saldo_j4),
    .ronda_num(ronda_num)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int erro_seen = 0;
  int ab_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-level model: a round is either collecting, waiting for its result, or idle.
  bit       m_valid = 0;
  bit       m_coll;
  int       m_pend;
  bit [3:0] m_mask;
  int       m_mv[4], m_bet[4], m_saldo[4];
  int       m_ronda, m_cnt;
  bit       e_erro, e_rv, e_ab;
  int       e_venc, e_emp;

  task automatic settle();
    int cnt[3];
    int nd, wm;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 4; i++) cnt[m_mv[i]]++;
    nd = 0;
    for (int k = 0; k < 3; k++) if (cnt[k] > 0) nd++;
    wm = -1;
    if (nd == 2)
      for (int k = 0; k < 3; k++) if (cnt[k] > 0 && cnt[(k + 2) % 3] > 0) wm = k;
    e_venc = 0;
    e_emp  = (wm < 0);
    if (wm >= 0)
      for (int i = 0; i < 4; i++) begin
        if (m_mv[i] == wm) begin
          e_venc |= (1 << i);
          m_saldo[i] = (m_saldo[i] + m_bet[i] > 255) ? 255 : m_saldo[i] + m_bet[i];
        end else m_saldo[i] = m_saldo[i] - m_bet[i];
      end
    m_ronda = (m_ronda + 1) % 256;
    e_rv = 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_coll = 0; m_pend = 0; m_mask = 0; m_ronda = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_saldo[i] = INI;
      e_venc = 0; e_emp = 0; e_erro = 0; e_rv = 0; e_ab = 0;
    end else begin
      e_erro = 0; e_rv = 0; e_ab = 0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) settle();
      end else if (m_coll) begin
        m_cnt++;
        if (jog_valid) begin
          if (jog_move == 2'd3 || m_mask[jog_id]) e_erro = 1;
          else begin
            m_mask[jog_id] = 1'b1;
            m_mv[jog_id]   = jog_move;
            m_bet[jog_id]  = (jog_aposta < m_saldo[jog_id]) ? jog_aposta : m_saldo[jog_id];
          end
        end
        if (m_mask == 4'hF) begin m_coll = 0; m_pend = 2; end
`ifdef GAME_ROUND_TIMEOUT_EN
        else if (m_cnt == TMO) begin m_coll = 0; e_ab = 1; end
`endif
      end else if (start) begin
        m_coll = 1; m_mask = 0; m_cnt = 0; e_venc = 0; e_emp = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (erro === 1'b1) erro_seen++;
    if (ronda_abortada === 1'b1) ab_seen++;
    if (m_valid) begin
      chk("jog_ready", jog_ready, m_coll);
      chk("ocupado", ocupado, (m_coll || m_pend > 0));
      chk("erro", erro, e_erro);
      chk("resultado_valid", resultado_valid, e_rv);
      chk("ronda_abortada", ronda_abortada, e_ab);
      chk("ronda_num", ronda_num, m_ronda);
      chk("saldo_j1", saldo_j1, m_saldo[0]);
      chk("saldo_j2", saldo_j2, m_saldo[1]);
      chk("saldo_j3", saldo_j3, m_saldo[2]);
      chk("saldo_j4", saldo_j4, m_saldo[3]);
      if (e_rv) begin
        chk("vencedores", vencedores, e_venc);
        chk("empate", empate, e_emp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_round();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic offer(input int id, input int mv, input int bet);
    jog_valid  = 1'b1;
    jog_id     = 2'(id);
    jog_move   = 2'(mv);
    jog_aposta = 7'(bet);
    tick();
    jog_valid  = 1'b0;
  endtask

  task automatic wait_rv(output int k);
    k = 0;
    while (resultado_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (resultado_valid !== 1'b1) chk("rv_timeout", 0, 1);
  endtask

  task automatic pin_saldos(input string tag, input int s1, input int s2, input int s3, input int s4);
    chk({tag, "_j1"}, saldo_j1, s1);
    chk({tag, "_j2"}, saldo_j2, s2);
    chk({tag, "_j3"}, saldo_j3, s3);
    chk({tag, "_j4"}, saldo_j4, s4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e0;
    rst_n = 1'b0; start = 1'b0; jog_valid = 1'b0;
    jog_id = '0; jog_move = '0; jog_aposta = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    pin_saldos("reset", 100, 100, 100, 100);
    chk("reset_ronda", ronda_num, 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_venc", vencedores, 0);

    // Papel vs three pedras: J1 wins
    begin_round();
    offer(0, 1, 50); offer(1, 0, 50); offer(2, 0, 25); offer(3, 0, 100);
    wait_rv(k);
    chk("latency", k + 1, 3);
    chk("A_venc", vencedores, 4'b0001);
    chk("A_empate", empate, 0);
    pin_saldos("A", 150, 50, 75, 0);
    chk("A_ronda", ronda_num, 1);

    // Start in the resultado_valid cycle; single move -> tie
    begin_round();
    offer(0, 0, 10); offer(1, 0, 10); offer(2, 0, 10); offer(3, 0, 10);
    wait_rv(k);
    chk("B_empate", empate, 1);
    chk("B_venc", vencedores, 0);
    pin_saldos("B", 150, 50, 75, 0);
    chk("B_ronda", ronda_num, 2);

    // Three distinct moves -> tie; start while busy is ignored
    tick();
    begin_round();
    offer(0, 0, 20); start = 1'b1; offer(1, 1, 20); start = 1'b0;
    offer(2, 2, 20); offer(3, 0, 20);
    wait_rv(k);
    chk("C_empate", empate, 1);
    pin_saldos("C", 150, 50, 75, 0);
    chk("C_ronda", ronda_num, 3);

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pin_saldos("rst2", 100, 100, 100, 100);
    chk("rst2_ronda", ronda_num, 0);

    // Tesoura beats papel: J3, J4 win
    begin_round();
    offer(0, 1, 50); offer(1, 1, 50); offer(2, 2, 25); offer(3, 2, 100);
    wait_rv(k);
    chk("D_venc", vencedores, 4'b1100);
    pin_saldos("D", 50, 50, 125, 200);

    // J4 pedra beats tesoura; credit saturates
    begin_round();
    offer(0, 2, 10); offer(1, 2, 10); offer(2, 2, 10); offer(3, 0, 100);
    wait_rv(k);
    chk("E_venc", vencedores, 4'b1000);
    pin_saldos("E", 40, 40, 115, 255);

    // Rejections and bet clamping
    e0 = erro_seen;
    begin_round();
    offer(0, 3, 5); offer(1, 0, 127); offer(1, 1, 5);
    offer(0, 1, 10); offer(2, 1, 10); offer(3, 1, 10);
    wait_rv(k);
    tick();
    chk("F_erro_count", erro_seen - e0, 2);
    chk("F_venc", vencedores, 4'b1101);
    pin_saldos("F", 50, 0, 125, 255);
    offer(0, 1, 1);
    tick();

    // Long stall in COLLECT with 3 moves
    begin_round();
    offer(0, 2, 5); offer(1, 2, 5); offer(2, 2, 5);
    repeat (100) tick();
`ifdef GAME_ROUND_TIMEOUT_EN
    chk("G_abort_count", ab_seen, 1);
    chk("G_ocupado", ocupado, 0);
    offer(3, 2, 5);
    tick();
    chk("G_ronda", ronda_num, 3);
`else
    chk("G_ocupado", ocupado, 1);
    chk("G_ready", jog_ready, 1);
    offer(3, 2, 5);
    wait_rv(k);
    chk("G_empate", empate, 1);
    chk("G_ronda", ronda_num, 4);
`endif

    // Reset while in EVAL
    tick();
    begin_round();
    offer(0, 1, 10); offer(1, 0, 10); offer(2, 0, 10); offer(3, 0, 10);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pin_saldos("H", 100, 100, 100, 100);
    chk("H_ronda", ronda_num, 0);
    repeat (5) tick();
    chk("H_ocupado", ocupado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
